issue_arbiter: RTL and testbench
================================

ISSUE_ARBITER -- requirements
Module: issue_arbiter

Interface
REQ-001 Parameter NUM_SLOT, default 8, number of issue slots arbitrated (power of two, >=2).
REQ-002 Parameter WIDTH_PRY, default 1, width of per-slot priority field.
REQ-003 Parameter WIDTH_LAT, default 3, width of per-slot occupancy-latency field.
REQ-004 Parameter WIDTH_IDX, default 3, log2(NUM_SLOT).
REQ-005 i_clk  input  1  single clock; all state updates on rising edge.
REQ-006 i_rst_n  input  1  reset, synchronous, active-low.
REQ-007 i_request  input  NUM_SLOT  per-slot request (o_request of each issue slot).
REQ-008 i_priority  input  NUM_SLOT*WIDTH_PRY  per-slot priority, slot k at bits [k*WIDTH_PRY +: WIDTH_PRY].
REQ-009 i_lat  input  NUM_SLOT*WIDTH_LAT  per-slot extra busy cycles of the functional unit (0 = fully pipelined).
REQ-010 i_fu_ready  input  1  functional unit can accept an op this cycle.
REQ-011 i_kill  input  1  branch kill: cancel the registered issue and the busy window.
REQ-012 o_grant  output  NUM_SLOT  one-hot or zero, combinational, drives each slot's i_grant.
REQ-013 o_issue_valid  output  1  registered: an op was granted last cycle.
REQ-014 o_issue_idx  output  WIDTH_IDX  registered index of last granted slot.
REQ-015 o_busy  output  1  arbiter in BUSY state.

Function
REQ-016 State machine SHALL have two states: READY, BUSY.
REQ-017 Grant enable SHALL be (state==READY) && i_fu_ready && !i_kill; otherwise o_grant SHALL be all zero.
REQ-018 When enabled and any i_request set, exactly one o_grant bit SHALL be set, same cycle (zero latency).
REQ-019 Winner SHALL be a requesting slot with maximum priority value; ties SHALL be broken round-robin, starting at rr pointer and searching upward with wrap from NUM_SLOT-1 to 0.
REQ-020 o_grant SHALL never assert for a slot whose i_request is low.
REQ-021 On a grant to slot g, rr pointer SHALL become (g+1) mod NUM_SLOT at next edge; otherwise unchanged.
REQ-022 On a grant, next cycle o_issue_valid=1 and o_issue_idx=g; with no grant, next cycle o_issue_valid=0 and o_issue_idx holds.
REQ-023 On a grant to slot g with lat_g=i_lat[g]!=0, state SHALL go to BUSY and busy counter load lat_g; with lat_g==0 state stays READY.
REQ-024 In BUSY, counter SHALL decrement each cycle; when counter==1 state returns to READY at next edge, so exactly lat_g cycles after the grant cycle have no grant.
REQ-025 i_kill high SHALL force next-cycle o_issue_valid=0, state READY, counter 0; rr pointer unchanged.
REQ-026 i_kill and a pending request in same cycle: no grant (REQ-017), kill wins.
REQ-027 i_fu_ready low in READY: no grant, no state change; in BUSY the counter SHALL still decrement.
REQ-028 o_busy SHALL equal (state==BUSY).

Reset
REQ-029 On rising edge with i_rst_n low: state READY, counter 0, rr pointer 0, o_issue_valid 0, o_issue_idx 0.
REQ-030 While i_rst_n low, o_grant SHALL be zero; reset overrides i_kill and grants in the same cycle.
REQ-031 Reset asserted during BUSY SHALL abort the busy window; first grant possible in the first cycle after i_rst_n returns high.

Verification
REQ-032 Single request: i_request=8'b0000_0100, pri 0, lat 0, fu_ready 1 -> o_grant=8'b0000_0100 same cycle; next cycle o_issue_valid=1, o_issue_idx=2.
REQ-033 Round-robin: all 8 requesting, equal pri, lat 0, 9 cycles -> grants to slots 0,1,...,7,0 in order.
REQ-034 Priority: i_request=8'b1000_0001, pri slot7=1, slot0=0 -> grant slot 7 regardless of rr pointer.
REQ-035 Busy: grant slot 3 with i_lat[3]=3 -> o_busy=1 for next 3 cycles, o_grant=0 for 3 cycles despite requests, grant resumes 4th cycle after.
REQ-036 Kill: i_kill=1 one cycle after grant with lat 2 -> o_issue_valid=0, o_busy=0 next cycle, grant possible the cycle after kill drops.
REQ-037 Reset: i_rst_n=0 for one edge mid-BUSY -> all outputs at REQ-029 values; rr restarts at slot 0.

Source files
------------

// File: rtl/issue_arbiter_if.sv
// Request/grant bundle between the issue slots and the issue arbiter.
// The arbiter connects through the slave modport and the slot array through the master modport.
interface issue_arbiter_if #(
    parameter int NUM_SLOT  = 8,
    parameter int WIDTH_PRY = 1,
    parameter int WIDTH_LAT = 3,
    parameter int WIDTH_IDX = 3
);
    logic [NUM_SLOT-1:0]           i_request;
    logic [NUM_SLOT*WIDTH_PRY-1:0] i_priority;
    logic [NUM_SLOT*WIDTH_LAT-1:0] i_lat;
    logic                          i_fu_ready;
    logic                          i_kill;
    logic [NUM_SLOT-1:0]           o_grant;
    logic                          o_issue_valid;
    logic [WIDTH_IDX-1:0]          o_issue_idx;
    logic                          o_busy;

    modport master (
        output i_request, i_priority, i_lat, i_fu_ready, i_kill,
        input  o_grant, o_issue_valid, o_issue_idx, o_busy
    );

    modport slave (
        input  i_request, i_priority, i_lat, i_fu_ready, i_kill,
        output o_grant, o_issue_valid, o_issue_idx, o_busy
    );
endinterface

// File: rtl/issue_arbiter.sv
// Single-issue arbiter: highest priority wins, ties are broken round-robin, and a granted
// op with non-zero latency blocks further grants for exactly that many cycles.
module issue_arbiter #(
    parameter int NUM_SLOT  = 8,
    parameter int WIDTH_PRY = 1,
    parameter int WIDTH_LAT = 3,
    parameter int WIDTH_IDX = 3
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    issue_arbiter_if.slave arb
);
    typedef enum logic {ST_READY, ST_BUSY} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH_LAT-1:0] count_reg, count_next;
    logic [WIDTH_IDX-1:0] rr_reg, rr_next;
    logic                 valid_reg, valid_next;
    logic [WIDTH_IDX-1:0] idx_reg, idx_next;

    logic [WIDTH_PRY-1:0] pri [NUM_SLOT];
    logic [WIDTH_LAT-1:0] lat [NUM_SLOT];
    logic [WIDTH_PRY-1:0] max_chain [NUM_SLOT+1];
    logic [NUM_SLOT-1:0]  eligible;
    logic [WIDTH_IDX-1:0] probe;
    logic [WIDTH_IDX-1:0] win_idx;
    logic                 found;
    logic                 grant_en;
    logic                 grant_fire;

    // Running maximum of the priorities of requesting slots.
    assign max_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_slot
            assign pri[gi] = arb.i_priority[gi*WIDTH_PRY +: WIDTH_PRY];
            assign lat[gi] = arb.i_lat[gi*WIDTH_LAT +: WIDTH_LAT];
            assign max_chain[gi+1] = (arb.i_request[gi] && (pri[gi] > max_chain[gi]))
                                     ? pri[gi] : max_chain[gi];
            assign eligible[gi] = arb.i_request[gi] && (pri[gi] == max_chain[NUM_SLOT]);
        end
    endgenerate

    // Among the top-priority requesters, take the first one at or above the rr pointer.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        probe   = '0;
        for (int off = 0; off < NUM_SLOT; off++) begin
            probe = rr_reg + off[WIDTH_IDX-1:0];
            if (!found && eligible[probe]) begin
                found   = 1'b1;
                win_idx = probe;
            end
        end
    end

    assign grant_en   = i_rst_n && (state_reg == ST_READY) && arb.i_fu_ready && !arb.i_kill;
    assign grant_fire = grant_en && found;

    always_comb begin
        arb.o_grant = '0;
        if (grant_fire) begin
            arb.o_grant[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        rr_next    = rr_reg;
        valid_next = grant_fire;
        idx_next   = grant_fire ? win_idx : idx_reg;
        if (arb.i_kill) begin
            state_next = ST_READY;
            count_next = '0;
            valid_next = 1'b0;
        end else begin
            case (state_reg)
                ST_READY: begin
                    if (grant_fire) begin
                        rr_next = win_idx + WIDTH_IDX'(1);
                        if (lat[win_idx] != '0) begin
                            state_next = ST_BUSY;
                            count_next = lat[win_idx];
                        end
                    end
                end
                ST_BUSY: begin
                    // Decrements regardless of fu_ready; the window is fixed at grant time.
                    count_next = count_reg - WIDTH_LAT'(1);
                    if (count_reg <= WIDTH_LAT'(1)) begin
                        state_next = ST_READY;
                        count_next = '0;
                    end
                end
                default: begin
                    state_next = ST_READY;
                    count_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= ST_READY;
            count_reg <= '0;
            rr_reg    <= '0;
            valid_reg <= 1'b0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            rr_reg    <= rr_next;
            valid_reg <= valid_next;
            idx_reg   <= idx_next;
        end
    end

    assign arb.o_issue_valid = valid_reg;
    assign arb.o_issue_idx   = idx_reg;
    assign arb.o_busy        = (state_reg == ST_BUSY);
endmodule

// File: tb/tb_issue_arbiter.sv
// Bench for issue_arbiter: directed vector table, multi-cycle corner sequences, and
// random traffic checked every cycle against a slot-level reference model.
module tb_issue_arbiter;
    localparam int N  = 8;
    localparam int WP = 1;
    localparam int WL = 3;
    localparam int WI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    issue_arbiter_if #(.NUM_SLOT(N), .WIDTH_PRY(WP), .WIDTH_LAT(WL), .WIDTH_IDX(WI)) bus ();

    issue_arbiter #(.NUM_SLOT(N), .WIDTH_PRY(WP), .WIDTH_LAT(WL), .WIDTH_IDX(WI)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .arb    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining blocked cycles, rr pointer, last issue.
    int m_busy  = 0;
    int m_rr    = 0;
    int m_valid = 0;
    int m_idx   = 0;
    bit m_on    = 1'b0;

    function automatic int m_winner(input logic [N-1:0] req, input logic [N*WP-1:0] pri, input int rr);
        int best = -1;
        int pk, pb, dk, db;
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                pk = int'(pri[k*WP +: WP]);
                dk = (k - rr + N) % N;
                if (best < 0) begin
                    best = k;
                end else begin
                    pb = int'(pri[best*WP +: WP]);
                    db = (best - rr + N) % N;
                    if (pk > pb || (pk == pb && dk < db)) best = k;
                end
            end
        end
        return best;
    endfunction

    function automatic int m_grant_slot();
        if (rst_n && m_busy == 0 && bus.i_fu_ready && !bus.i_kill)
            return m_winner(bus.i_request, bus.i_priority, m_rr);
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        w = m_grant_slot();
        if (!rst_n) begin
            m_busy = 0; m_rr = 0; m_valid = 0; m_idx = 0; m_on = 1'b1;
        end else if (bus.i_kill) begin
            m_busy = 0; m_valid = 0;
        end else if (w >= 0) begin
            m_valid = 1; m_idx = w; m_rr = (w + 1) % N;
            m_busy = int'(bus.i_lat[w*WL +: WL]);
        end else begin
            m_valid = 0;
            if (m_busy > 0) m_busy--;
        end
    end

    always @(negedge clk) begin
        int w;
        logic [N-1:0] g;
        if (m_on) begin
            w = m_grant_slot();
            g = '0;
            if (w >= 0) g[w] = 1'b1;
            chk("model_grant", 32'(bus.o_grant), 32'(g));
            chk("model_valid", 32'(bus.o_issue_valid), 32'(m_valid));
            chk("model_idx", 32'(bus.o_issue_idx), 32'(m_idx));
            chk("model_busy", 32'(bus.o_busy), 32'(m_busy > 0));
        end
    end

    // Apply one cycle of inputs just after the rising edge, then wait for the sampling edge.
    task automatic drive(input bit rst, input logic [N-1:0] req, input logic [N*WP-1:0] pri,
                         input logic [N*WL-1:0] lat, input bit fu, input bit kill);
        @(posedge clk);
        #1;
        rst_n          = rst;
        bus.i_request  = req;
        bus.i_priority = pri;
        bus.i_lat      = lat;
        bus.i_fu_ready = fu;
        bus.i_kill     = kill;
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst;
        logic [7:0]  req;
        logic [7:0]  pri;
        logic [23:0] lat;
        bit          fu;
        bit          kill;
        logic [7:0]  g;
        bit          v;
        logic [2:0]  idx;
        bit          busy;
    } vec_t;

    vec_t tbl [12];

    initial begin
        bus.i_request  = '0;
        bus.i_priority = '0;
        bus.i_lat      = '0;
        bus.i_fu_ready = 1'b0;
        bus.i_kill     = 1'b0;

        // Registered fields are what is visible during that row, i.e. the result of earlier rows.
        tbl[0]  = '{1, 8'h04, 8'h00, 24'h0, 1, 0, 8'h04, 0, 3'd0, 0};
        tbl[1]  = '{1, 8'h00, 8'h00, 24'h0, 1, 0, 8'h00, 1, 3'd2, 0};
        tbl[2]  = '{1, 8'h81, 8'h80, 24'h0, 1, 0, 8'h80, 0, 3'd2, 0};
        tbl[3]  = '{1, 8'h81, 8'h80, 24'h0, 1, 0, 8'h80, 1, 3'd7, 0};
        tbl[4]  = '{1, 8'hFF, 8'h00, 24'h0, 0, 0, 8'h00, 1, 3'd7, 0};
        tbl[5]  = '{1, 8'hFF, 8'h00, 24'h0, 1, 1, 8'h00, 0, 3'd7, 0};
        tbl[6]  = '{1, 8'hFF, 8'h00, 24'h0, 1, 0, 8'h01, 0, 3'd7, 0};
        tbl[7]  = '{1, 8'h0A, 8'h00, 24'h0, 1, 0, 8'h02, 1, 3'd0, 0};
        tbl[8]  = '{1, 8'h0A, 8'h00, 24'h0, 1, 0, 8'h08, 1, 3'd1, 0};
        tbl[9]  = '{1, 8'h0A, 8'h00, 24'h0, 1, 0, 8'h02, 1, 3'd3, 0};
        tbl[10] = '{0, 8'hFF, 8'h00, 24'h0, 1, 0, 8'h00, 1, 3'd1, 0};
        tbl[11] = '{1, 8'h80, 8'h00, 24'h0, 1, 0, 8'h80, 0, 3'd0, 0};

        drive(0, '0, '0, '0, 1, 0);
        drive(0, '0, '0, '0, 1, 0);
        chk("reset_valid", 32'(bus.o_issue_valid), 32'(0));
        chk("reset_idx", 32'(bus.o_issue_idx), 32'(0));
        chk("reset_busy", 32'(bus.o_busy), 32'(0));

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].pri, tbl[i].lat, tbl[i].fu, tbl[i].kill);
            chk($sformatf("tbl%0d_grant", i), 32'(bus.o_grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.o_issue_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_idx", i), 32'(bus.o_issue_idx), 32'(tbl[i].idx));
            chk($sformatf("tbl%0d_busy", i), 32'(bus.o_busy), 32'(tbl[i].busy));
        end

        // Round-robin over all requesters with equal priority.
        drive(0, 8'hFF, '0, '0, 1, 0);
        chk("rr_reset_grant", 32'(bus.o_grant), 32'(0));
        for (int i = 0; i < 9; i++) begin
            drive(1, 8'hFF, '0, '0, 1, 0);
            chk($sformatf("rr_grant%0d", i), 32'(bus.o_grant), 32'(1) << (i % 8));
        end

        // Busy window of three cycles after granting slot 3.
        drive(0, '0, '0, '0, 1, 0);
        drive(1, 8'h08, '0, 24'h000600, 1, 0);
        chk("busy_first_grant", 32'(bus.o_grant), 32'h08);
        for (int j = 0; j < 3; j++) begin
            drive(1, 8'hFF, '0, 24'h000600, 1, 0);
            chk($sformatf("busy_blk%0d_grant", j), 32'(bus.o_grant), 32'(0));
            chk($sformatf("busy_blk%0d_busy", j), 32'(bus.o_busy), 32'(1));
        end
        drive(1, 8'h08, '0, 24'h000600, 1, 0);
        chk("busy_resume_grant", 32'(bus.o_grant), 32'h08);
        chk("busy_resume_busy", 32'(bus.o_busy), 32'(0));

        // Kill one cycle into a two-cycle busy window.
        drive(0, '0, '0, '0, 1, 0);
        drive(1, 8'h08, '0, 24'h000400, 1, 0);
        chk("kill_first_grant", 32'(bus.o_grant), 32'h08);
        drive(1, 8'h08, '0, 24'h000400, 1, 1);
        chk("kill_cycle_grant", 32'(bus.o_grant), 32'(0));
        chk("kill_cycle_valid", 32'(bus.o_issue_valid), 32'(1));
        chk("kill_cycle_busy", 32'(bus.o_busy), 32'(1));
        drive(1, 8'h08, '0, 24'h000400, 1, 0);
        chk("kill_after_valid", 32'(bus.o_issue_valid), 32'(0));
        chk("kill_after_busy", 32'(bus.o_busy), 32'(0));
        chk("kill_after_grant", 32'(bus.o_grant), 32'h08);

        // Reset in the middle of a long busy window.
        drive(0, '0, '0, '0, 1, 0);
        drive(1, 8'h20, '0, 24'h038000, 1, 0);
        chk("rst_first_grant", 32'(bus.o_grant), 32'h20);
        drive(1, 8'hFF, '0, '0, 1, 0);
        chk("rst_busy", 32'(bus.o_busy), 32'(1));
        drive(0, 8'hFF, '0, '0, 1, 0);
        chk("rst_low_grant", 32'(bus.o_grant), 32'(0));
        drive(1, 8'hFF, '0, '0, 1, 0);
        chk("rst_after_valid", 32'(bus.o_issue_valid), 32'(0));
        chk("rst_after_idx", 32'(bus.o_issue_idx), 32'(0));
        chk("rst_after_busy", 32'(bus.o_busy), 32'(0));
        chk("rst_after_grant", 32'(bus.o_grant), 32'h01);

        // Random traffic; the model checker compares every cycle.
        for (int c = 0; c < 3000; c++) begin
            logic [N*WL-1:0] lat;
            lat = '0;
            for (int k = 0; k < N; k++)
                if ($urandom_range(3) == 0) lat[k*WL +: WL] = WL'($urandom_range(7));
            drive($urandom_range(49) != 0, N'($urandom), (N*WP)'($urandom), lat,
                  $urandom_range(4) != 0, $urandom_range(19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
